cpu_controller: RTL

Multi-cycle control unit for the 4-bit processor: fetches 12-bit instructions from a synchronous instruction ROM and decodes them. It owns a four-entry 4-bit register file, sequences the shared 4-bit ALU through a fixed fetch/decode/execute/writeback cycle, and handles immediate loads, jumps, conditional jumps and halt. It sits between the instruction ROM and the ALU and is the only master of both.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/cpu_controller_reg_file.sv | 35 +++
 rtl/cpu_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit processor control unit: opcodes, FSM states
// and instruction field positions.
package cpu_pkg;

  localparam int DATA_W = 4;

  localparam int OP_HI  = 11;
  localparam int OP_LO  = 8;
  localparam int RX_HI  = 7;
  localparam int RX_LO  = 6;
  localparam int RY_HI  = 5;
  localparam int RY_LO  = 4;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LDI  = 4'b0001;
  localparam logic [3:0] OP_JMP  = 4'b0010;
  localparam logic [3:0] OP_JZ   = 4'b0011;
  localparam logic [3:0] OP_HALT = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b1100;
  localparam logic [3:0] OP_SUB  = 4'b1101;
  localparam logic [3:0] OP_AND  = 4'b1110;
  localparam logic [3:0] OP_NOT  = 4'b1111;
  localparam logic [1:0] OP_MOV_PREFIX = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic writes_reg(input logic [3:0] op);
    return is_alu_op(op) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/cpu_controller_reg_file.sv
// Four-entry register file: two combinational operand reads, one debug read,
// one synchronous write port.
module reg_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        rd_sel_a,
  input  logic [1:0]        rd_sel_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [1:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wr_sel] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = regs[rd_sel_a];
    rd_data_b = regs[rd_sel_b];
    dbg_data  = regs[dbg_sel];
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control unit: fetch/decode/execute/writeback sequencing of the
// instruction ROM, the register file and the external ALU.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int PC_W = 4,
  parameter int IW   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [PC_W-1:0]   instr_addr,
  input  logic [IW-1:0]     instr_data,
  output logic [DATA_W-1:0] alu_rx,
  output logic [DATA_W-1:0] alu_ry,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              busy,
  output logic              halted,
  output logic              zero,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [IW-1:0]     ir;
  logic [DATA_W-1:0] result;

  logic [1:0]        rd_sel_a;
  logic [1:0]        rd_sel_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        ir_op;
  logic [3:0]        dec_op;
  logic              jump_taken;

  assign instr_addr = pc;
  assign ir_op      = ir[OP_HI:OP_LO];
  assign dec_op     = instr_data[OP_HI:OP_LO];

  // Operands are latched into the ALU drive registers at the end of DECODE,
  // so the read ports follow the incoming word there and the held ir elsewhere.
  always_comb begin
    rd_sel_a = ir[RX_HI:RX_LO];
    rd_sel_b = ir[RY_HI:RY_LO];
    if (state == S_DECODE) begin
      rd_sel_a = instr_data[RX_HI:RX_LO];
      rd_sel_b = instr_data[RY_HI:RY_LO];
    end
  end

  always_comb begin
    wr_en      = (state == S_WRITEBACK) && writes_reg(ir_op);
    wr_data    = is_alu_op(ir_op) ? result : ir[IMM_HI:IMM_LO];
    jump_taken = (ir_op == OP_JMP) || ((ir_op == OP_JZ) && zero);
  end

  reg_file u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .rd_sel_a  (rd_sel_a),
    .rd_sel_b  (rd_sel_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data),
    .we        (wr_en),
    .wr_sel    (ir[RX_HI:RX_LO]),
    .wr_data   (wr_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      pc     <= '0;
      ir     <= '0;
      result <= '0;
      zero   <= 1'b0;
      halted <= 1'b0;
      busy   <= 1'b0;
      alu_op <= '0;
      alu_rx <= '0;
      alu_ry <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            pc     <= '0;
            halted <= 1'b0;
            busy   <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          ir <= instr_data;
          if (dec_op == OP_HALT) begin
            halted <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else begin
            alu_op <= dec_op;
            alu_rx <= rd_data_a;
            alu_ry <= rd_data_b;
            state  <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          result <= alu_out;
          alu_op <= '0;
          alu_rx <= '0;
          alu_ry <= '0;
          state  <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (wr_en) zero <= (wr_data == '0);
          if (jump_taken) pc <= PC_W'(ir[IMM_HI:IMM_LO]);
          else            pc <= pc + PC_W'(1);
          state <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
